// File: rtl/ps2_key_sequencer.sv
// Decodes PS/2 set-2 scan-code bytes into command-key events, tracks held keys,
// and queues events in a first-word-fall-through FIFO with a valid/ready handshake.
module ps2_key_sequencer #(
    parameter int DEPTH     = 4,
    parameter int REPEAT_EN = 0,
    parameter int TIMEOUT   = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_err,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [2:0]             evt_code,
    output logic [4:0]             held,
    output logic [$clog2(DEPTH):0] evt_count,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic                   seq_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] CODE_NONE  = 3'd0;
    localparam logic [2:0] CODE_ENTER = 3'd1;
    localparam logic [2:0] CODE_SPACE = 3'd2;
    localparam logic [2:0] CODE_BKSP  = 3'd3;
    localparam logic [2:0] CODE_UP    = 3'd4;
    localparam logic [2:0] CODE_DOWN  = 3'd5;

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

    state_t         state, state_nx;
    logic [2:0]     skip_cnt, skip_nx;
    logic [TW-1:0]  to_cnt, to_nx;
    logic [4:0]     held_nx;
    logic           seq_err_nx;
    logic [2:0]     make_code, brk_code;
    logic           push;
    logic [2:0]     push_code;

    logic [2:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           full, pop, push_ok, drop;

    function automatic logic [4:0] code_mask(input logic [2:0] code);
        case (code)
            CODE_ENTER: return 5'b00001;
            CODE_SPACE: return 5'b00010;
            CODE_BKSP:  return 5'b00100;
            CODE_UP:    return 5'b01000;
            CODE_DOWN:  return 5'b10000;
            default:    return 5'b00000;
        endcase
    endfunction

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx   = state;
        skip_nx    = skip_cnt;
        to_nx      = to_cnt;
        seq_err_nx = 1'b0;
        make_code  = CODE_NONE;
        brk_code   = CODE_NONE;

        if (rx_err) begin
            state_nx   = IDLE;
            to_nx      = '0;
            seq_err_nx = (state != IDLE);
        end else if (rx_valid) begin
            to_nx = '0;
            case (state)
                IDLE: begin
                    case (rx_byte)
                        8'hE0: state_nx = EXT;
                        8'hF0: state_nx = BRK;
                        8'hE1: begin
                            state_nx = SKIP;
                            skip_nx  = 3'd7;
                        end
                        8'h5A: make_code = CODE_ENTER;
                        8'h29: make_code = CODE_SPACE;
                        8'h66: make_code = CODE_BKSP;
                        default: ;
                    endcase
                end
                EXT: begin
                    state_nx = IDLE;
                    case (rx_byte)
                        8'hF0: state_nx = EXT_BRK;
                        8'hE0: state_nx = EXT;
                        8'h75: make_code = CODE_UP;
                        8'h72: make_code = CODE_DOWN;
                        8'h5A: make_code = CODE_ENTER;
                        default: ;
                    endcase
                end
                BRK: begin
                    state_nx = IDLE;
                    case (rx_byte)
                        8'h5A: brk_code = CODE_ENTER;
                        8'h29: brk_code = CODE_SPACE;
                        8'h66: brk_code = CODE_BKSP;
                        default: ;
                    endcase
                end
                EXT_BRK: begin
                    state_nx = IDLE;
                    case (rx_byte)
                        8'h75: brk_code = CODE_UP;
                        8'h72: brk_code = CODE_DOWN;
                        8'h5A: brk_code = CODE_ENTER;
                        default: ;
                    endcase
                end
                SKIP: begin
                    skip_nx = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (to_cnt == TO_LAST) begin
                state_nx   = IDLE;
                to_nx      = '0;
                seq_err_nx = 1'b1;
            end else begin
                to_nx = to_cnt + 1'b1;
            end
        end

        // A make of an already-held key is a typematic repeat.
        push      = (make_code != CODE_NONE) &&
                    (((held & code_mask(make_code)) == 5'b0) || (REPEAT_EN != 0));
        push_code = make_code;
        held_nx   = (held | code_mask(make_code)) & ~code_mask(brk_code);
    end

    assign evt_valid = (evt_count != '0);
    assign full      = (evt_count == CW'(DEPTH));
    assign pop       = evt_valid && evt_ready;
    assign push_ok   = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign evt_code  = evt_valid ? mem[rd_ptr] : 3'd0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            skip_cnt  <= '0;
            to_cnt    <= '0;
            held      <= '0;
            seq_err   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            state    <= state_nx;
            skip_cnt <= skip_nx;
            to_cnt   <= to_nx;
            held     <= held_nx;
            seq_err  <= seq_err_nx;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   evt_count <= evt_count + 1'b1;
                2'b01:   evt_count <= evt_count - 1'b1;
                default: ;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    // NOTE: storage is not reset; emptiness is tracked by evt_count and evt_code is masked when empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_code;
    end

endmodule

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
- Sits between the PS/2 byte receiver and the menu/text-entry logic.
- Consumes validated scan-code bytes and decodes the set-2 prefixes: E0 (extended), F0 (break) and E1 (pause).
- Tracks which of the five command keys are held, filters typematic repeats, and queues one-hot-free key events in a small FIFO with a valid/ready handshake.
- Watchdogs incomplete prefix sequences.

Parameters:
- DEPTH, 4: event FIFO depth; must be a power of 2 and at least 2.
- REPEAT_EN, 0: 1 = typematic repeat makes of a held key are queued; 0 = they are dropped.
- TIMEOUT, 100000: clk cycles allowed between bytes of a multi-byte sequence (2 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- rx_byte  in  8  received scan-code byte
- rx_err  in  1  one-cycle strobe, receiver framing/parity error
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_code  out  3  head event: 1 Enter, 2 Space, 3 Backspace, 4 Up, 5 Down
- held  out  5  held-key bitmap; bit0 Enter, bit1 Space, bit2 Backspace, bit3 Up, bit4 Down
- evt_count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky, set on event dropped at full FIFO
- ovf_clr  in  1  clears overflow
- seq_err  out  1  one-cycle pulse on aborted sequence

Behaviour:
- Reset:
  - Applies at a clk edge with rst_n=0.
  - State goes to IDLE; FIFO is emptied.
  - evt_valid=0, evt_code=0, held=0, evt_count=0, overflow=0, seq_err=0.
  - Timeout and skip counters are cleared.
  - Reset mid-sequence or mid-FIFO discards everything.
- States: IDLE, EXT, BRK, EXT_BRK, SKIP.
- Transitions on rx_valid:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> SKIP with skip_cnt=7.
    - 5A, 29, 66 -> make of Enter, Space, Backspace; stay IDLE.
    - AA, FA, EE, FE, 00, FF and all other bytes are ignored; stay IDLE.
    - Non-extended 75 and 72 (keypad) are ignored.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay EXT.
    - 75 -> Up make; 72 -> Down make; 5A (keypad Enter) -> Enter make.
    - Any other byte, including 12 (fake shift), is ignored.
    - All bytes except F0 and E0 -> IDLE.
  - BRK:
    - 5A, 29, 66 -> clear the matching held bit.
    - Any byte -> IDLE.
  - EXT_BRK:
    - 75, 72, 5A -> clear the Up, Down, Enter held bit.
    - Any byte -> IDLE.
  - SKIP:
    - Each byte decrements skip_cnt.
    - The byte that brings skip_cnt to 0 -> IDLE.
    - No events are generated.
- Make handling:
  - Held bit clear: set it and generate the event.
  - Held bit already set: generate the event only if REPEAT_EN=1.
  - Enter and keypad Enter share bit0.
- rx_err:
  - Any state -> IDLE; the byte is discarded.
  - rx_err together with rx_valid: rx_err wins.
  - seq_err pulses only if the state was not IDLE.
  - held is unchanged.
- Timeout:
  - In EXT, BRK, EXT_BRK and SKIP, the counter increments each cycle without rx_valid and resets on rx_valid.
  - When the counter reaches TIMEOUT: -> IDLE, seq_err pulses for 1 cycle, counter clears.
  - The counter is held at 0 in IDLE.
- FIFO:
  - First-word fall-through, registered.
  - Event decoded at edge N (rx_valid high before edge N); with FIFO empty, evt_valid=1 and evt_code valid after edge N, i.e. 1-cycle latency.
  - Pop occurs when evt_valid && evt_ready at an edge.
  - evt_code is stable while evt_valid && !evt_ready.
  - Push when full with no pop: event dropped, overflow set.
  - Push and pop in the same cycle when full: push accepted, count unchanged, no overflow.
  - Push and pop in the same cycle when empty is impossible, since there is no head.
  - Pointers wrap modulo DEPTH.
- overflow:
  - ovf_clr=1 clears it.
  - A drop in the same cycle as ovf_clr leaves overflow set, since set wins.
- evt_count equals the number of entries, 0..DEPTH.

Test Plan:
- Bytes 29, F0 29 with evt_ready=1 -> one event, code 2; held[1]=1 after 29 and 0 after F0 29; evt_valid high exactly 1 cycle, 1 cycle after the 29 strobe.
- Bytes E0 75, E0 72, 75 (keypad) with evt_ready=0 -> evt_count=2; head code 4 then 5 after one pop; held=5'b11000.
- REPEAT_EN=0: bytes 66 66 66 F0 66 -> one event, code 3. REPEAT_EN=1: same bytes -> three events, code 3.
- DEPTH=4, evt_ready=0, 5 distinct makes (5A 29 66 E0 75 E0 72) -> evt_count=4, overflow=1, codes 1,2,3,4 popped in order. ovf_clr -> overflow=0.
- Byte E0 then no traffic for TIMEOUT cycles -> seq_err pulse at cycle TIMEOUT, state IDLE; following 5A -> event code 1.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> no events, held unchanged. F0 followed by rx_err -> seq_err=1, next 29 -> event code 2. rst_n=0 with 3 queued events -> evt_count=0, held=0 on the next edge.
